enemy_spawner: RTL and testbench
================================

// Module: enemy_spawner
// PURPOSE
//  Game-logic stage directly upstream of the enemy sprite renderer; sole source of its pos/hit inputs.
//  Picks a pseudo-random hole (1..9 = Q W E / A S D / Z X C), shows an enemy there for a lifetime.
//  Resolves player key presses into hit / wrong-key events.
//  Keeps score and escape counts; lifetime shrinks as score grows.
// PARAMETERS
//  GAP_TICKS   5      ticks with no enemy (pos=0) between enemies
//  LIFE_TICKS  20     base enemy lifetime in ticks
//  LIFE_MIN    6      floor on lifetime
//  HIT_TICKS   3      ticks hit is held after a successful hit
//  ESC_TICKS   3      ticks pos=10 (escaped marker) is held after timeout
//  LFSR_SEED   8'hA5  reset seed of position LFSR; must be nonzero
// PORTS
//  clk        in   1  system clock; only clock
//  rst        in   1  synchronous, active-high reset
//  tick       in   1  one-cycle game-time strobe, same clock domain
//  game_en    in   1  level; low forces idle
//  key_valid  in   1  one-cycle key-press strobe
//  key_code   in   4  1..9 = hole key; other values are invalid
//  pos        out  4  0 = none, 1..9 = enemy hole, 10 = escaped marker
//  hit        out  1  high while in HIT state
//  score      out  8  successful hits, saturates at 255
//  escapes    out  8  timeouts, saturates at 255
//  wrong_key  out  1  one-cycle pulse: valid key pressed during SHOW but not matching pos
// BEHAVIOUR
//  Reset: pos=0, hit=0, score=0, escapes=0, wrong_key=0, state=GAP, cnt=GAP_TICKS, lfsr=LFSR_SEED.
//  All outputs registered. Response to key_valid/tick is visible on outputs on the next cycle.
//  LFSR: 8-bit, taps x^8+x^6+x^5+x^4+1. Advances every clk cycle, independent of game_en.
//  Dwell timing: on state entry, cnt is loaded with the dwell value N. Each tick decrements cnt.
//    A tick seen while cnt==1 causes the transition, so each state lasts exactly N ticks.
//  Lifetime: life = max(LIFE_MIN, LIFE_TICKS - score[7:3]), computed on SHOW entry.
//    Computed at 8-bit width with no underflow.
//  FSM:
//   GAP     pos=0, hit=0. On expiry -> SHOW.
//           New pos = (lfsr mod 9)+1; if equal to previous hole, pos+1, with 9 wrapping to 1.
//   SHOW    pos=hole.
//           key_valid & key_code==pos -> HIT; score+1 (sat).
//           key_valid & key_code in 1..9 & !=pos -> wrong_key pulse, stay.
//           Lifetime expiry -> ESCAPED; escapes+1 (sat).
//   HIT     pos=hole, hit=1. On expiry -> GAP.
//   ESCAPED pos=10, hit=0. On expiry -> GAP.
//  key_valid outside SHOW, or key_code 0/10..15, is ignored: no pulse, no state change.
//  Matching key and lifetime expiry in the same cycle: hit wins; escapes not incremented.
//  game_en=0: next cycle state=GAP, cnt=GAP_TICKS, pos=0, hit=0. score/escapes retained.
//    Ticks and keys are ignored while game_en=0.
//  rst mid-operation overrides everything and restores reset values on the next edge.
// STRUCTURE
//  enemy_pkg: state encoding (GAP/SHOW/HIT/ESCAPED), POS_NONE=0, POS_ESCAPED=10, KEY_MIN=1, KEY_MAX=9.
//  Sub-module lfsr_pos_gen: 8-bit LFSR, seed/reset, mod-9 hole mapping, repeat avoidance.
//  Top holds the FSM, the dwell counter, score/escape counters and output registers.
// TESTING
//  1 rst=1 for 2 cycles, then game_en=1, 5 ticks -> pos in 1..9 one cycle after 5th tick; hit=0.
//  2 In SHOW (score=0), key_valid with key_code=pos -> next cycle hit=1, score=1.
//    After 3 ticks -> pos=0.
//  3 In SHOW, no key for 20 ticks -> pos=10, escapes=1. After 3 more ticks -> pos=0.
//  4 In SHOW at pos=4, key_code=7 -> wrong_key high exactly 1 cycle; pos stays 4; score unchanged.
//    key_code=0 or 12 -> no pulse.
//  5 Matching key_valid and the expiring tick in the same cycle -> hit=1, escapes unchanged.
//  6 Preload score=255 via 255 hits -> another hit keeps score=255; life=LIFE_MIN.
//    Drop game_en mid-SHOW -> pos=0 next cycle, score held.

Source files
------------

// File: rtl/enemy_pkg.sv
// Shared encodings and helpers for the enemy spawner game-logic stage.
package enemy_pkg;

    typedef enum logic [1:0] {
        ST_GAP     = 2'd0,
        ST_SHOW    = 2'd1,
        ST_HIT     = 2'd2,
        ST_ESCAPED = 2'd3
    } state_t;

    localparam logic [3:0] POS_NONE    = 4'd0;
    localparam logic [3:0] POS_ESCAPED = 4'd10;
    localparam logic [3:0] KEY_MIN     = 4'd1;
    localparam logic [3:0] KEY_MAX     = 4'd9;

    // True for key codes that name a hole (1..9).
    function automatic logic key_is_hole(input logic [3:0] code);
        return (code >= KEY_MIN) && (code <= KEY_MAX);
    endfunction

    // Lifetime shrinks by one tick per 8 points of score, floored at life_min.
    // Evaluated at 8 bits; the subtraction is guarded so it can never wrap.
    function automatic logic [7:0] life_calc(input logic [7:0] score,
                                             input logic [7:0] life_base,
                                             input logic [7:0] life_min);
        logic [7:0] dec;
        dec = {3'b000, score[7:3]};
        if ((life_base > dec) && ((life_base - dec) > life_min)) begin
            return life_base - dec;
        end
        return life_min;
    endfunction

endpackage

// File: rtl/lfsr_pos_gen.sv
// Free-running 8-bit LFSR (x^8+x^6+x^5+x^4+1) mapped onto holes 1..9.
// The candidate hole is bumped by one (9 wraps to 1) when it equals the hole
// picked last time, so the enemy never reappears in the same place twice in a row.
// The seed must be nonzero, otherwise the register locks up at zero.
module lfsr_pos_gen
    import enemy_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       take_i,
    output logic [3:0] hole_o
);

    logic [7:0] lfsr_q, lfsr_d;
    logic [3:0] prev_q;
    logic [7:0] rem;
    logic [3:0] cand;

    // Next LFSR value and the repeat-avoiding hole mapping.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        rem    = lfsr_q % 8'd9;
        cand   = rem[3:0] + 4'd1;
        hole_o = cand;
        if (cand == prev_q) begin
            hole_o = (cand == KEY_MAX) ? KEY_MIN : cand + 4'd1;
        end
    end

    // LFSR steps every cycle; the last hole is remembered when the top takes one.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
            prev_q <= POS_NONE;
        end else begin
            lfsr_q <= lfsr_d;
            if (take_i) begin
                prev_q <= hole_o;
            end
        end
    end

endmodule

// File: rtl/enemy_spawner.sv
// Enemy spawner: hole selection, dwell timing, key resolution and scoring.
//
//  state      | meaning
//  -----------+-----------------------------------------------
//  ST_GAP     | no enemy shown (pos=0), waiting GAP_TICKS
//  ST_SHOW    | enemy visible at hole, waiting for key or lifetime
//  ST_HIT     | enemy was hit, hit=1 held for HIT_TICKS
//  ST_ESCAPED | enemy timed out, pos=10 held for ESC_TICKS
module enemy_spawner
    import enemy_pkg::*;
#(
    parameter int unsigned GAP_TICKS  = 5,
    parameter int unsigned LIFE_TICKS = 20,
    parameter int unsigned LIFE_MIN   = 6,
    parameter int unsigned HIT_TICKS  = 3,
    parameter int unsigned ESC_TICKS  = 3,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       game_en,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] pos,
    output logic       hit,
    output logic [7:0] score,
    output logic [7:0] escapes,
    output logic       wrong_key
);

    localparam logic [7:0] GAP_N  = 8'(GAP_TICKS);
    localparam logic [7:0] LIFE_N = 8'(LIFE_TICKS);
    localparam logic [7:0] LMIN_N = 8'(LIFE_MIN);
    localparam logic [7:0] HIT_N  = 8'(HIT_TICKS);
    localparam logic [7:0] ESC_N  = 8'(ESC_TICKS);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] hole_q, hole_d;
    logic [7:0] score_q, score_d;
    logic [7:0] esc_q, esc_d;
    logic [3:0] pos_q, pos_d;
    logic       hit_q, hit_d;
    logic       wrong_q, wrong_d;
    logic       take;
    logic       expire;
    logic [3:0] hole_gen;

    lfsr_pos_gen #(
        .LFSR_SEED (LFSR_SEED)
    ) u_pos_gen (
        .clk    (clk),
        .rst    (rst),
        .take_i (take),
        .hole_o (hole_gen)
    );

    assign expire = tick && (cnt_q == 8'd1);

    // Next-state, dwell counter, counters and registered-output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hole_d  = hole_q;
        score_d = score_q;
        esc_d   = esc_q;
        wrong_d = 1'b0;
        take    = 1'b0;
        pos_d   = POS_NONE;
        hit_d   = 1'b0;

        if (!game_en) begin
            state_d = ST_GAP;
            cnt_d   = GAP_N;
        end else begin
            case (state_q)
                ST_GAP: begin
                    if (expire) begin
                        state_d = ST_SHOW;
                        hole_d  = hole_gen;
                        take    = 1'b1;
                        cnt_d   = life_calc(score_q, LIFE_N, LMIN_N);
                    end else if (tick) begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                ST_SHOW: begin
                    // A matching key takes priority over a simultaneous expiry.
                    if (key_valid && (key_code == hole_q)) begin
                        state_d = ST_HIT;
                        cnt_d   = HIT_N;
                        score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    end else begin
                        if (key_valid && key_is_hole(key_code)) begin
                            wrong_d = 1'b1;
                        end
                        if (expire) begin
                            state_d = ST_ESCAPED;
                            cnt_d   = ESC_N;
                            esc_d   = (esc_q == 8'hFF) ? esc_q : esc_q + 8'd1;
                        end else if (tick) begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end
                end
                ST_HIT, ST_ESCAPED: begin
                    if (expire) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_N;
                    end else if (tick) begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_N;
                end
            endcase
        end

        case (state_d)
            ST_SHOW:    pos_d = hole_d;
            ST_HIT: begin
                pos_d = hole_d;
                hit_d = 1'b1;
            end
            ST_ESCAPED: pos_d = POS_ESCAPED;
            default:    pos_d = POS_NONE;
        endcase
    end

    // State, counters and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_GAP;
            cnt_q   <= GAP_N;
            hole_q  <= POS_NONE;
            score_q <= 8'd0;
            esc_q   <= 8'd0;
            pos_q   <= POS_NONE;
            hit_q   <= 1'b0;
            wrong_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hole_q  <= hole_d;
            score_q <= score_d;
            esc_q   <= esc_d;
            pos_q   <= pos_d;
            hit_q   <= hit_d;
            wrong_q <= wrong_d;
        end
    end

    assign pos       = pos_q;
    assign hit       = hit_q;
    assign score     = score_q;
    assign escapes   = esc_q;
    assign wrong_key = wrong_q;

endmodule

// File: tb/tb_enemy_spawner.sv
// Self-checking bench for enemy_spawner: directed sequences plus a vector table
// of key/tick patterns applied while an enemy is on screen.
module tb_enemy_spawner;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       game_en;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] pos;
    logic       hit;
    logic [7:0] score;
    logic [7:0] escapes;
    logic       wrong_key;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_lfsr;
    logic [3:0] m_prev;
    logic [3:0] hole;
    logic [7:0] exp_score;
    logic [7:0] exp_esc;

    localparam logic [1:0] K_LIT = 2'd0, K_MATCH = 2'd1, K_WRONG = 2'd2;
    localparam logic [1:0] P_NONE = 2'd0, P_HOLE = 2'd1, P_ESC = 2'd2;

    typedef struct {
        logic       t;
        logic       kv;
        logic [1:0] ksel;
        logic [3:0] klit;
        logic [1:0] psel;
        logic       ehit;
        logic       ewrong;
        logic       sinc;
    } vec_t;

    vec_t vecs[13];

    enemy_spawner dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .game_en   (game_en),
        .key_valid (key_valid),
        .key_code  (key_code),
        .pos       (pos),
        .hit       (hit),
        .score     (score),
        .escapes   (escapes),
        .wrong_key (wrong_key)
    );

    always #5 clk = ~clk;

    // Reference position LFSR, x^8+x^6+x^5+x^4+1, stepping every clock.
    always @(posedge clk) begin
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic logic [3:0] pick(input logic [7:0] l, input logic [3:0] prev);
        logic [7:0] r;
        logic [3:0] h;
        r = l % 8'd9;
        h = r[3:0] + 4'd1;
        if (h == prev) h = (h == 4'd9) ? 4'd1 : h + 4'd1;
        return h;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic t, input logic kv, input logic [3:0] kc);
        tick      = t;
        key_valid = kv;
        key_code  = kc;
        @(posedge clk);
        #1;
        tick      = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 4'd0);
    endtask

    // From a fresh GAP: four ticks keep pos=0, the fifth shows the model's hole.
    task automatic enter_show();
        logic [3:0] e;
        ticks(4);
        chk("gap_pos", {4'd0, pos}, 8'd0);
        e = pick(m_lfsr, m_prev);
        cyc(1'b1, 1'b0, 4'd0);
        m_prev = e;
        hole   = e;
        chk("show_pos", {4'd0, pos}, {4'd0, e});
        chk("show_hit", {7'd0, hit}, 8'd0);
    endtask

    task automatic do_hit();
        enter_show();
        cyc(1'b0, 1'b1, hole);
        exp_score = (exp_score == 8'hFF) ? 8'hFF : exp_score + 8'd1;
        chk("hit_flag", {7'd0, hit}, 8'd1);
        chk("hit_score", score, exp_score);
        ticks(3);
        chk("hit_done_pos", {4'd0, pos}, 8'd0);
    endtask

    task automatic escape_test(input int life);
        enter_show();
        ticks(life - 1);
        chk("esc_before_pos", {4'd0, pos}, {4'd0, hole});
        cyc(1'b1, 1'b0, 4'd0);
        exp_esc = exp_esc + 8'd1;
        chk("esc_pos", {4'd0, pos}, 8'd10);
        chk("esc_count", escapes, exp_esc);
        chk("esc_hit", {7'd0, hit}, 8'd0);
        ticks(2);
        chk("esc_hold_pos", {4'd0, pos}, 8'd10);
        cyc(1'b1, 1'b0, 4'd0);
        chk("esc_done_pos", {4'd0, pos}, 8'd0);
    endtask

    initial begin
        logic [3:0] kc;
        logic [3:0] ep;

        //          t     kv    ksel     klit   psel    ehit  ewr   sinc
        vecs[0]  = '{1'b0, 1'b1, K_WRONG, 4'd0,  P_HOLE, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, K_LIT,   4'd0,  P_HOLE, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, K_LIT,   4'd0,  P_HOLE, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, K_LIT,   4'd12, P_HOLE, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, K_LIT,   4'd10, P_HOLE, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, K_WRONG, 4'd0,  P_HOLE, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, K_LIT,   4'd0,  P_HOLE, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, K_MATCH, 4'd0,  P_HOLE, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, K_WRONG, 4'd0,  P_HOLE, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, K_LIT,   4'd0,  P_HOLE, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, K_LIT,   4'd0,  P_NONE, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, K_MATCH, 4'd0,  P_NONE, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, K_WRONG, 4'd0,  P_NONE, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; game_en = 1'b0; tick = 1'b0; key_valid = 1'b0; key_code = 4'd0;
        m_prev = 4'd0; hole = 4'd0; exp_score = 8'd0; exp_esc = 8'd0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_pos", {4'd0, pos}, 8'd0);
        chk("rst_hit", {7'd0, hit}, 8'd0);
        chk("rst_score", score, 8'd0);
        chk("rst_escapes", escapes, 8'd0);
        chk("rst_wrong", {7'd0, wrong_key}, 8'd0);

        // First enemy appears one cycle after the fifth tick.
        game_en = 1'b1;
        enter_show();
        chk("first_pos_range", {7'd0, (pos >= 4'd1 && pos <= 4'd9)}, 8'd1);

        // Hit, held for three ticks.
        cyc(1'b0, 1'b1, hole);
        exp_score = 8'd1;
        chk("t2_hit", {7'd0, hit}, 8'd1);
        chk("t2_score", score, exp_score);
        chk("t2_pos", {4'd0, pos}, {4'd0, hole});
        ticks(2);
        chk("t2_hold_hit", {7'd0, hit}, 8'd1);
        cyc(1'b1, 1'b0, 4'd0);
        chk("t2_done_pos", {4'd0, pos}, 8'd0);
        chk("t2_done_hit", {7'd0, hit}, 8'd0);

        // Full-lifetime escape at low score.
        escape_test(20);

        // Vector table while an enemy is shown.
        enter_show();
        for (int i = 0; i < 13; i++) begin
            case (vecs[i].ksel)
                K_MATCH: kc = hole;
                K_WRONG: kc = (hole == 4'd9) ? 4'd1 : hole + 4'd1;
                default: kc = vecs[i].klit;
            endcase
            case (vecs[i].psel)
                P_HOLE:  ep = hole;
                P_ESC:   ep = 4'd10;
                default: ep = 4'd0;
            endcase
            cyc(vecs[i].t, vecs[i].kv, kc);
            if (vecs[i].sinc) exp_score = exp_score + 8'd1;
            chk($sformatf("vec%0d_pos", i), {4'd0, pos}, {4'd0, ep});
            chk($sformatf("vec%0d_hit", i), {7'd0, hit}, {7'd0, vecs[i].ehit});
            chk($sformatf("vec%0d_wrong", i), {7'd0, wrong_key}, {7'd0, vecs[i].ewrong});
            chk($sformatf("vec%0d_score", i), score, exp_score);
        end

        // Matching key on the expiring tick: hit wins, no escape counted.
        enter_show();
        ticks(19);
        cyc(1'b1, 1'b1, hole);
        exp_score = exp_score + 8'd1;
        chk("t5_hit", {7'd0, hit}, 8'd1);
        chk("t5_pos", {4'd0, pos}, {4'd0, hole});
        chk("t5_escapes", escapes, exp_esc);
        chk("t5_score", score, exp_score);
        ticks(3);
        chk("t5_done_pos", {4'd0, pos}, 8'd0);

        // Lifetime shortens once score reaches 8, floors at LIFE_MIN near saturation.
        while (exp_score < 8'd8) do_hit();
        escape_test(19);
        while (exp_score < 8'd255) do_hit();
        do_hit();
        chk("sat_score", score, 8'd255);
        escape_test(6);

        // Dropping game_en mid-SHOW.
        enter_show();
        ticks(2);
        game_en = 1'b0;
        cyc(1'b0, 1'b0, 4'd0);
        chk("dis_pos", {4'd0, pos}, 8'd0);
        chk("dis_hit", {7'd0, hit}, 8'd0);
        chk("dis_score", score, 8'd255);
        chk("dis_escapes", escapes, exp_esc);
        cyc(1'b1, 1'b1, hole);
        chk("dis_key_pos", {4'd0, pos}, 8'd0);
        chk("dis_key_wrong", {7'd0, wrong_key}, 8'd0);
        chk("dis_key_score", score, 8'd255);
        game_en = 1'b1;
        enter_show();

        // Reset in the middle of SHOW.
        rst = 1'b1;
        cyc(1'b1, 1'b1, hole);
        rst = 1'b0;
        m_prev = 4'd0; exp_score = 8'd0; exp_esc = 8'd0;
        chk("mrst_pos", {4'd0, pos}, 8'd0);
        chk("mrst_hit", {7'd0, hit}, 8'd0);
        chk("mrst_score", score, 8'd0);
        chk("mrst_escapes", escapes, 8'd0);
        chk("mrst_wrong", {7'd0, wrong_key}, 8'd0);
        enter_show();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
